ahb_slave_if: RTL and testbench
===============================

// Module: ahb_slave_if
// PURPOSE
//  AHB-Lite subordinate interface: the responder end of the ahb_master_if link.
//  Samples AHB address phases and checks them. Valid transfers become a single-beat request on a simple
//  local "other" bus. Local ready/error/rdata map back to HREADYOUT/HRESP/HRDATA, with wait states and a
//  two-cycle ERROR response. A wait timeout keeps a stalled local target from hanging the bus.
// PARAMETERS
//  AHB_ADDR_WIDTH   32  address width
//  AHB_DATA_WIDTH   32  data width (32 or 64); strobe width SW = AHB_DATA_WIDTH/8
//  AHB_WAIT_TIMEOUT 6   max local wait cycles before ERROR; 0 = timeout disabled
// PORTS
//  ahb_clk_in         in   1   clock, all logic on rising edge
//  ahb_rst_in         in   1   reset, synchronous, active-high
//  ahb_sel_in         in   1   HSEL
//  ahb_addr_in        in   AW  HADDR
//  ahb_trans_in       in   2   HTRANS (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
//  ahb_size_in        in   3   HSIZE
//  ahb_write_in       in   1   HWRITE
//  ahb_wdata_in       in   DW  HWDATA (data phase)
//  ahb_strb_in        in   SW  HWSTRB, data phase (only with AHB_WSTRB_EN)
//  ahb_ready_in       in   1   HREADY from bus mux
//  ahb_readyout_out   out  1   HREADYOUT, registered
//  ahb_resp_out       out  1   HRESP (0 OKAY, 1 ERROR), registered
//  ahb_rdata_out      out  DW  HRDATA, registered
//  other_valid_out    out  1   local request valid
//  other_addr_out     out  AW  latched address
//  other_size_out     out  3   latched size
//  other_write_out    out  1   latched direction
//  other_wdata_out    out  DW  = ahb_wdata_in while other_valid_out && write, else 0
//  other_strb_out     out  SW  byte lanes of the access
//  other_rdata_in     in   DW  local read data, valid with other_ready_in
//  other_ready_in     in   1   local completes the request this cycle
//  other_error_in     in   1   local error, qualified by other_ready_in
// BEHAVIOUR
//  Reset: state IDLE, readyout=1, resp=0, rdata=0, other_valid_out=0, other_addr/size/write/strb=0,
//   timeout counter=0. Reset mid-ACCESS drops valid next cycle; no AHB response is issued.
//  Sample point: ahb_sel_in && ahb_ready_in in IDLE, DONE or ERR2.
//   trans IDLE/BUSY, or no sample -> go to IDLE (zero-wait OKAY).
//   trans NONSEQ/SEQ: SEQ is handled exactly like NONSEQ; the address is always taken from HADDR.
//  Check: error if size > log2(SW), or if addr & ((1<<size)-1) != 0.
//   Check fails -> ERR1; no local request.
//   Check passes -> latch addr/size/write, go to ACCESS.
//  States (outputs registered from next state):
//   IDLE   readyout=1, resp=0.
//   ACCESS readyout=0, other_valid_out=1, timeout counter increments each cycle.
//          other_ready_in && !other_error_in -> DONE; rdata latched on reads, 0 on writes.
//          other_ready_in && other_error_in -> ERR1.
//          Timeout: counter reaches AHB_WAIT_TIMEOUT-1 without other_ready_in -> ERR1.
//          Valid is therefore held at most AHB_WAIT_TIMEOUT cycles.
//   DONE   readyout=1, resp=0; next sample may go directly to ACCESS (back-to-back pipelining).
//   ERR1   readyout=0, resp=1, other_valid_out=0.
//   ERR2   readyout=1, resp=1 (second ERROR cycle); sampling allowed.
//  Latency: a local ready in the first ACCESS cycle gives one AHB wait state.
//   N local wait cycles give N+1 AHB wait states.
//  Timeout counter is cleared on every entry to ACCESS. Counter width = $clog2(AHB_WAIT_TIMEOUT+1).
//  Local inputs are ignored outside ACCESS.
// CONFIGURATION
//  AHB_WSTRB_EN defined: ahb_strb_in is present; other_strb_out = ahb_strb_in during ACCESS.
//  AHB_WSTRB_EN undefined: other_strb_out = ((1<<(1<<size))-1) << addr[log2(SW)-1:0], from the latched
//   size/addr. Reads use this generated value in both builds.
// TESTING
//  Reset: hold ahb_rst_in 2 cycles mid-ACCESS -> readyout=1, resp=0, valid=0, rdata=0.
//  Write: NONSEQ addr 0x10, size 2, wdata 0xDEADBEEF, local ready on first cycle -> valid 1 cycle,
//   strb 4'hF, wdata 0xDEADBEEF, readyout low 1 cycle then 1, resp 0.
//  Read: addr 0x13, size 0, local ready after 3 waits, rdata 0x12345678 -> strb 4'b1000,
//   readyout low 4 cycles, then 1 with HRDATA 0x12345678.
//  Misaligned: size 2, addr 0x2 -> no valid; readyout/resp = 0/1 then 1/1.
//  Timeout (=6): local never ready -> valid high exactly 6 cycles, then two-cycle ERROR.
//  Pipelined: second NONSEQ sampled in DONE -> ACCESS next cycle, no IDLE gap.
//   BUSY/IDLE sampled -> zero-wait OKAY.

Source files
------------

// File: rtl/ahb_slave_if.sv
// AHB-Lite subordinate: checks address phases and forwards good transfers as single-beat local requests.
// Optional build macro AHB_WSTRB_EN adds ahb_strb_in and passes it to other_strb_out on writes.
module ahb_slave_if #(
    parameter int AHB_ADDR_WIDTH   = 32,
    parameter int AHB_DATA_WIDTH   = 32,
    parameter int AHB_WAIT_TIMEOUT = 6
) (
    input  logic                        ahb_clk_in,
    input  logic                        ahb_rst_in,
    input  logic                        ahb_sel_in,
    input  logic [AHB_ADDR_WIDTH-1:0]   ahb_addr_in,
    input  logic [1:0]                  ahb_trans_in,
    input  logic [2:0]                  ahb_size_in,
    input  logic                        ahb_write_in,
    input  logic [AHB_DATA_WIDTH-1:0]   ahb_wdata_in,
`ifdef AHB_WSTRB_EN
    input  logic [AHB_DATA_WIDTH/8-1:0] ahb_strb_in,
`endif
    input  logic                        ahb_ready_in,
    output logic                        ahb_readyout_out,
    output logic                        ahb_resp_out,
    output logic [AHB_DATA_WIDTH-1:0]   ahb_rdata_out,
    output logic                        other_valid_out,
    output logic [AHB_ADDR_WIDTH-1:0]   other_addr_out,
    output logic [2:0]                  other_size_out,
    output logic                        other_write_out,
    output logic [AHB_DATA_WIDTH-1:0]   other_wdata_out,
    output logic [AHB_DATA_WIDTH/8-1:0] other_strb_out,
    input  logic [AHB_DATA_WIDTH-1:0]   other_rdata_in,
    input  logic                        other_ready_in,
    input  logic                        other_error_in
);

    localparam int SW = AHB_DATA_WIDTH / 8;
    localparam int AL = $clog2(SW);
    localparam int CW = (AHB_WAIT_TIMEOUT > 0) ? $clog2(AHB_WAIT_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (AHB_WAIT_TIMEOUT > 0) ? CW'(AHB_WAIT_TIMEOUT - 1) : '0;

    localparam logic [1:0] TRANS_NONSEQ = 2'd2;
    localparam logic [1:0] TRANS_SEQ    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_DONE   = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_t;

    state_t                    state_q;
    logic                      readyout_q;
    logic                      resp_q;
    logic [AHB_DATA_WIDTH-1:0] rdata_q;
    logic                      valid_q;
    logic [AHB_ADDR_WIDTH-1:0] addr_q;
    logic [2:0]                size_q;
    logic                      write_q;
    logic [SW-1:0]             strb_q;
    logic [CW-1:0]             cnt_q;

    logic                      sample_req;
    logic                      check_err;
    logic                      timeout_hit;
    logic [AHB_ADDR_WIDTH-1:0] align_mask;
    logic [SW-1:0]             strb_d;

    // SEQ is treated exactly like NONSEQ; the address always comes from HADDR.
    always_comb begin
        sample_req  = ahb_sel_in && ahb_ready_in &&
                      (ahb_trans_in == TRANS_NONSEQ || ahb_trans_in == TRANS_SEQ);
        align_mask  = (AHB_ADDR_WIDTH'(1) << ahb_size_in) - AHB_ADDR_WIDTH'(1);
        check_err   = (ahb_size_in > 3'(AL)) || (|(ahb_addr_in & align_mask));
        timeout_hit = (AHB_WAIT_TIMEOUT != 0) && (cnt_q == CNT_LAST);
        strb_d      = '0;
        for (int i = 0; i < SW; i++) begin
            if (i >= int'(ahb_addr_in[AL-1:0]) &&
                i < int'(ahb_addr_in[AL-1:0]) + (1 << ahb_size_in)) begin
                strb_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge ahb_clk_in) begin
        if (ahb_rst_in) begin
            state_q    <= ST_IDLE;
            readyout_q <= 1'b1;
            resp_q     <= 1'b0;
            rdata_q    <= '0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            strb_q     <= '0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                ST_ACCESS: begin
                    if (other_ready_in) begin
                        valid_q <= 1'b0;
                        if (other_error_in) begin
                            state_q    <= ST_ERR1;
                            readyout_q <= 1'b0;
                            resp_q     <= 1'b1;
                        end else begin
                            state_q    <= ST_DONE;
                            readyout_q <= 1'b1;
                            resp_q     <= 1'b0;
                            rdata_q    <= write_q ? '0 : other_rdata_in;
                        end
                    end else if (timeout_hit) begin
                        state_q    <= ST_ERR1;
                        valid_q    <= 1'b0;
                        readyout_q <= 1'b0;
                        resp_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_ERR1: begin
                    state_q    <= ST_ERR2;
                    readyout_q <= 1'b1;
                    resp_q     <= 1'b1;
                end
                default: begin
                    // IDLE, DONE and ERR2 are the states in which an address phase can be accepted.
                    rdata_q <= '0;
                    if (sample_req && check_err) begin
                        state_q    <= ST_ERR1;
                        readyout_q <= 1'b0;
                        resp_q     <= 1'b1;
                    end else if (sample_req) begin
                        state_q    <= ST_ACCESS;
                        readyout_q <= 1'b0;
                        resp_q     <= 1'b0;
                        valid_q    <= 1'b1;
                        addr_q     <= ahb_addr_in;
                        size_q     <= ahb_size_in;
                        write_q    <= ahb_write_in;
                        strb_q     <= strb_d;
                        cnt_q      <= '0;
                    end else begin
                        state_q    <= ST_IDLE;
                        readyout_q <= 1'b1;
                        resp_q     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign ahb_readyout_out = readyout_q;
    assign ahb_resp_out     = resp_q;
    assign ahb_rdata_out    = rdata_q;
    assign other_valid_out  = valid_q;
    assign other_addr_out   = addr_q;
    assign other_size_out   = size_q;
    assign other_write_out  = write_q;
    assign other_wdata_out  = (valid_q && write_q) ? ahb_wdata_in : '0;

`ifdef AHB_WSTRB_EN
    assign other_strb_out = (state_q == ST_ACCESS && write_q) ? ahb_strb_in : strb_q;
`else
    assign other_strb_out = strb_q;
`endif

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if: write, waited read, misaligned, timeout, pipelining, BUSY/IDLE, reset.
module tb_ahb_slave_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  hstrb;
    logic        hready;
    logic        readyout;
    logic        resp;
    logic [31:0] rdata;
    logic        o_valid;
    logic [31:0] o_addr;
    logic [2:0]  o_size;
    logic        o_write;
    logic [31:0] o_wdata;
    logic [3:0]  o_strb;
    logic [31:0] o_rdata;
    logic        o_ready;
    logic        o_error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ahb_slave_if #(
        .AHB_ADDR_WIDTH(32),
        .AHB_DATA_WIDTH(32),
        .AHB_WAIT_TIMEOUT(6)
    ) dut (
        .ahb_clk_in(clk),
        .ahb_rst_in(rst),
        .ahb_sel_in(sel),
        .ahb_addr_in(addr),
        .ahb_trans_in(trans),
        .ahb_size_in(size),
        .ahb_write_in(write),
        .ahb_wdata_in(wdata),
`ifdef AHB_WSTRB_EN
        .ahb_strb_in(hstrb),
`endif
        .ahb_ready_in(hready),
        .ahb_readyout_out(readyout),
        .ahb_resp_out(resp),
        .ahb_rdata_out(rdata),
        .other_valid_out(o_valid),
        .other_addr_out(o_addr),
        .other_size_out(o_size),
        .other_write_out(o_write),
        .other_wdata_out(o_wdata),
        .other_strb_out(o_strb),
        .other_rdata_in(o_rdata),
        .other_ready_in(o_ready),
        .other_error_in(o_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One address phase, then the bus returns to an unselected IDLE.
    task automatic addr_phase(input logic [31:0] a, input logic [2:0] s, input logic w,
                              input logic [1:0] t);
        sel   = 1'b1;
        addr  = a;
        size  = s;
        write = w;
        trans = t;
        tick();
        sel   = 1'b0;
        trans = 2'd0;
        addr  = 32'h0;
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; addr = '0; trans = 2'd0; size = 3'd0; write = 1'b0;
        wdata = '0; hstrb = '0; hready = 1'b1; o_rdata = '0; o_ready = 1'b0; o_error = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_readyout", 64'(readyout), 64'h1);
        check("rst_resp",     64'(resp),     64'h0);
        check("rst_valid",    64'(o_valid),  64'h0);
        check("rst_rdata",    64'(rdata),    64'h0);
        check("rst_strb",     64'(o_strb),   64'h0);
        check("rst_addr",     64'(o_addr),   64'h0);

        // Write, local ready in the first ACCESS cycle
        addr_phase(32'h10, 3'd2, 1'b1, 2'd2);
        wdata = 32'hDEADBEEF; o_ready = 1'b1;
        #1;
        check("wr_valid",    64'(o_valid),  64'h1);
        check("wr_readyout", 64'(readyout), 64'h0);
        check("wr_addr",     64'(o_addr),   64'h10);
        check("wr_size",     64'(o_size),   64'h2);
        check("wr_write",    64'(o_write),  64'h1);
        check("wr_strb",     64'(o_strb),   64'hF);
        check("wr_wdata",    64'(o_wdata),  64'hDEADBEEF);
        tick();
        o_ready = 1'b0;
        check("wr_done_readyout", 64'(readyout), 64'h1);
        check("wr_done_resp",     64'(resp),     64'h0);
        check("wr_done_valid",    64'(o_valid),  64'h0);
        check("wr_done_wdata",    64'(o_wdata),  64'h0);
        wdata = '0;
        tick();

        // Read of one byte at 0x13, three local wait cycles
        addr_phase(32'h13, 3'd0, 1'b0, 2'd2);
        check("rd_strb",  64'(o_strb),  64'h8);
        check("rd_write", 64'(o_write), 64'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rd_wait%0d_readyout", i), 64'(readyout), 64'h0);
            check($sformatf("rd_wait%0d_valid", i),    64'(o_valid),  64'h1);
            if (i == 3) begin
                o_ready = 1'b1; o_rdata = 32'h12345678;
            end
            tick();
        end
        o_ready = 1'b0; o_rdata = 32'hFFFFFFFF;
        check("rd_done_readyout", 64'(readyout), 64'h1);
        check("rd_done_resp",     64'(resp),     64'h0);
        check("rd_done_rdata",    64'(rdata),    64'h12345678);
        tick();
        check("rd_idle_readyout", 64'(readyout), 64'h1);
        o_rdata = '0;

        // Misaligned word at 0x2
        addr_phase(32'h2, 3'd2, 1'b1, 2'd2);
        check("mis_err1_valid",    64'(o_valid),  64'h0);
        check("mis_err1_readyout", 64'(readyout), 64'h0);
        check("mis_err1_resp",     64'(resp),     64'h1);
        tick();
        check("mis_err2_readyout", 64'(readyout), 64'h1);
        check("mis_err2_resp",     64'(resp),     64'h1);
        tick();
        check("mis_idle_resp", 64'(resp), 64'h0);

        // Oversized transfer (doubleword on a 32-bit bus)
        addr_phase(32'h0, 3'd3, 1'b0, 2'd2);
        check("size_err_valid", 64'(o_valid), 64'h0);
        check("size_err_resp",  64'(resp),   64'h1);
        tick(); tick();

        // Timeout: local target never answers
        addr_phase(32'h20, 3'd2, 1'b0, 2'd2);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("to_valid%0d", i),    64'(o_valid),  64'h1);
            check($sformatf("to_readyout%0d", i), 64'(readyout), 64'h0);
            tick();
        end
        check("to_err1_valid",    64'(o_valid),  64'h0);
        check("to_err1_readyout", 64'(readyout), 64'h0);
        check("to_err1_resp",     64'(resp),     64'h1);
        tick();
        check("to_err2_readyout", 64'(readyout), 64'h1);
        check("to_err2_resp",     64'(resp),     64'h1);
        tick();

        // Local error response
        addr_phase(32'h24, 3'd2, 1'b1, 2'd2);
        o_ready = 1'b1; o_error = 1'b1;
        tick();
        o_ready = 1'b0; o_error = 1'b0;
        check("lerr_err1_readyout", 64'(readyout), 64'h0);
        check("lerr_err1_resp",     64'(resp),     64'h1);
        tick();
        check("lerr_err2_resp", 64'(resp), 64'h1);
        tick();

        // Back-to-back: second NONSEQ accepted in DONE
        addr_phase(32'h40, 3'd2, 1'b1, 2'd2);
        wdata = 32'h0BADF00D; o_ready = 1'b1;
        tick();
        check("pipe_done_readyout", 64'(readyout), 64'h1);
        o_ready = 1'b0; wdata = '0;
        addr_phase(32'h44, 3'd2, 1'b0, 2'd2);
        check("pipe_acc_valid",    64'(o_valid),  64'h1);
        check("pipe_acc_addr",     64'(o_addr),   64'h44);
        check("pipe_acc_write",    64'(o_write),  64'h0);
        check("pipe_acc_readyout", 64'(readyout), 64'h0);
        o_ready = 1'b1; o_rdata = 32'hCAFEF00D;
        tick();
        o_ready = 1'b0; o_rdata = '0;
        check("pipe_rd_rdata", 64'(rdata), 64'hCAFEF00D);
        tick();

        // SEQ halfword at 0x62 behaves like NONSEQ
        addr_phase(32'h62, 3'd1, 1'b1, 2'd3);
        check("seq_valid", 64'(o_valid), 64'h1);
        check("seq_strb",  64'(o_strb),  64'hC);
        check("seq_addr",  64'(o_addr),  64'h62);
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
        tick();

        // BUSY and IDLE: zero-wait OKAY, no local request
        addr_phase(32'h50, 3'd2, 1'b1, 2'd1);
        check("busy_valid",    64'(o_valid),  64'h0);
        check("busy_readyout", 64'(readyout), 64'h1);
        check("busy_resp",     64'(resp),     64'h0);
        addr_phase(32'h54, 3'd2, 1'b1, 2'd0);
        check("idle_valid",    64'(o_valid),  64'h0);
        check("idle_readyout", 64'(readyout), 64'h1);

        // Reset held two cycles in the middle of an ACCESS
        addr_phase(32'h80, 3'd2, 1'b0, 2'd2);
        check("rst2_pre_valid", 64'(o_valid), 64'h1);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst2_valid",    64'(o_valid),  64'h0);
        check("rst2_readyout", 64'(readyout), 64'h1);
        check("rst2_resp",     64'(resp),     64'h0);
        check("rst2_rdata",    64'(rdata),    64'h0);
        tick();
        check("rst2_after_readyout", 64'(readyout), 64'h1);
        check("rst2_after_valid",    64'(o_valid),  64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
